// File: rtl/bcd_sumres_scan.sv
// Add/subtract of two unsigned operands, displayed as sign plus magnitude on a
// multiplexed 7-segment display.
//   clk, reset           : system clock, asynchronous active-high reset
//   selector_suma_resta  : 0 = A+B, 1 = A-B
//   input_top_1/2        : operands A and B, unsigned WIDTH bits
//   SSeg                 : active-low segments, SSeg[0]=a .. SSeg[6]=g
//   an                   : active-low digit anodes, an[0] = units
//   busy                 : conversion in progress
//   done                 : one-cycle pulse when the display registers update
// The magnitude is converted to BCD by a sequential double-dabble FSM. The
// leftmost digit shows the minus sign; the other digits use leading-zero blanking.
module bcd_sumres_scan #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             selector_suma_resta,
  input  logic [WIDTH-1:0] input_top_1,
  input  logic [WIDTH-1:0] input_top_2,
  output logic [6:0]       SSeg,
  output logic [NDIG-1:0]  an,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MagW   = WIDTH + 1;
  localparam int unsigned BcdDig = NDIG - 1;
  localparam int unsigned BcdW   = 4 * BcdDig;
  localparam int unsigned CntW   = $clog2(WIDTH + 2);
  localparam int unsigned IdxW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PreW   = $clog2(DIV);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);
  localparam logic [6:0]      SegBlank = 7'b1111111;
  localparam logic [6:0]      SegMinus = 7'b0111111;

  logic [1:0]       state_q, state_d;
  logic             first_q, first_d;
  logic             snap_sel_q, snap_sel_d;
  logic [WIDTH-1:0] snap_a_q, snap_a_d;
  logic [WIDTH-1:0] snap_b_q, snap_b_d;
  logic [MagW-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]  bcd_q, bcd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [BcdW-1:0]  disp_bcd_q, disp_bcd_d;
  logic             disp_neg_q, disp_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic [MagW-1:0]  mag;
  logic             neg;
  logic             changed;
  logic [BcdW-1:0]  bcd_adj;

  // Sign/magnitude of the live inputs; used only on the capture edge, when the
  // inputs and the new snapshot are identical.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    if (!selector_suma_resta) begin
      mag = {1'b0, input_top_1} + {1'b0, input_top_2};
    end else if (input_top_1 >= input_top_2) begin
      mag = {1'b0, input_top_1 - input_top_2};
    end else begin
      mag = {1'b0, input_top_2 - input_top_1};
      neg = 1'b1;
    end
  end

  assign changed = first_q ||
      ({selector_suma_resta, input_top_1, input_top_2} != {snap_sel_q, snap_a_q, snap_b_q});

  // Double-dabble correction: nibbles >= 5 get +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BcdDig); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    snap_sel_d = snap_sel_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (changed) begin
          snap_sel_d = selector_suma_resta;
          snap_a_d   = input_top_1;
          snap_b_d   = input_top_2;
          first_d    = 1'b0;
          shift_d    = mag;
          neg_d      = neg;
          bcd_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH)) state_d = StDone;
      end
      StDone: begin
        disp_bcd_d = bcd_q;
        disp_neg_d = neg_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan prescaler and digit index, free-running.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PreW'(DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      first_q    <= 1'b1;
      snap_sel_q <= 1'b0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      snap_sel_q <= snap_sel_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SegBlank;
    endcase
  endfunction

  // lz[i]: digits i and everything above it (below the sign digit) are zero.
  logic [BcdDig-1:0] lz;
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz = '0;
    for (int i = int'(BcdDig) - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_bcd_q[4*i +: 4] == 4'd0);
      lz[i] = zero_above;
    end
  end

  always_comb begin
    SSeg = SegBlank;
    if (idx_q == LastIdx) begin
      SSeg = disp_neg_q ? SegMinus : SegBlank;
    end else begin
      for (int i = 0; i < int'(BcdDig); i++) begin
        if (idx_q == IdxW'(i)) begin
          SSeg = (i > 0 && lz[i]) ? SegBlank : seg_of(disp_bcd_q[4*i +: 4]);
        end
      end
    end
  end

  assign an   = ~(NDIG'(1) << idx_q);
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_sumres_scan.sv
module tb_bcd_sumres_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic [7:0] a, b;
  logic [6:0] sseg;
  logic [3:0] an;
  logic       busy, done;

  int n_checks = 0;
  int n_fails  = 0;
  int n;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_MINUS = 7'b0111111;
  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000;
  localparam logic [6:0] S_4 = 7'b0011001;
  localparam logic [6:0] S_5 = 7'b0010010;
  localparam logic [6:0] S_7 = 7'b1111000;

  bcd_sumres_scan #(
    .WIDTH(8),
    .NDIG (4),
    .DIV  (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .selector_suma_resta(sel),
    .input_top_1        (a),
    .input_top_2        (b),
    .SSeg               (sseg),
    .an                 (an),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until done is seen; -1 if the bound expires.
  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < max);
    if (!done) cnt = -1;
  endtask

  task automatic check_digit(input int i, input logic [6:0] exp, input string tag);
    logic [3:0] want;
    int k;
    want = ~(4'b0001 << i);
    k = 0;
    while (an !== want && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_an"}, an, want);
    chk(tag, sseg, exp);
  endtask

  initial begin
    logic [3:0] an_seq [5];
    int k;
    an_seq[0] = 4'b1110;
    an_seq[1] = 4'b1101;
    an_seq[2] = 4'b1011;
    an_seq[3] = 4'b0111;
    an_seq[4] = 4'b1110;

    // Reset state
    reset = 1'b1; sel = 1'b0; a = 8'd255; b = 8'd255;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_an", an, 4'b1110);
    chk("rst_sseg", sseg, S_0);

    // 1: 255+255 = 510, forced conversion after reset release
    reset = 1'b0;
    wait_done(40, n);
    chk("t1_latency", n, 11);
    chk("t1_busy_at_done", busy, 1'b0);
    check_digit(3, S_BLANK, "t1_d3");
    check_digit(2, S_5, "t1_d2");
    check_digit(1, S_1, "t1_d1");
    check_digit(0, S_0, "t1_d0");

    // 2: 3-10 = -7
    sel = 1'b1; a = 8'd3; b = 8'd10;
    wait_done(40, n);
    chk("t2_latency", n, 11);
    check_digit(3, S_MINUS, "t2_d3");
    check_digit(2, S_BLANK, "t2_d2");
    check_digit(1, S_BLANK, "t2_d1");
    check_digit(0, S_7, "t2_d0");

    // 3: 0-0 = 0, no minus
    sel = 1'b1; a = 8'd0; b = 8'd0;
    wait_done(40, n);
    chk("t3_latency", n, 11);
    check_digit(3, S_BLANK, "t3_d3");
    check_digit(2, S_BLANK, "t3_d2");
    check_digit(1, S_BLANK, "t3_d1");
    check_digit(0, S_0, "t3_d0");

    // 4: 100+23 with B changed to 200 mid-conversion
    sel = 1'b0; a = 8'd100; b = 8'd23;
    @(negedge clk);
    chk("t4_busy_cap", busy, 1'b1);
    repeat (2) @(negedge clk);
    b = 8'd200;
    wait_done(40, n);
    chk("t4_first_latency", n, 8);
    chk("t4_gap_busy", busy, 1'b0);
    @(negedge clk);
    chk("t4_restart_busy", busy, 1'b1);
    chk("t4_restart_done", done, 1'b0);
    wait_done(40, n);
    chk("t4_second_latency", n, 10);
    check_digit(3, S_BLANK, "t4_d3");
    check_digit(2, S_3, "t4_d2");
    check_digit(1, S_0, "t4_d1");
    check_digit(0, S_0, "t4_d0");

    // 5: reset during SHIFT, then 5-9 = -4
    sel = 1'b0; a = 8'd200; b = 8'd100;
    repeat (4) @(negedge clk);
    chk("t5_busy_shift", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_an", an, 4'b1110);
    chk("t5_rst_sseg", sseg, S_0);
    @(negedge clk);
    sel = 1'b1; a = 8'd5; b = 8'd9;
    reset = 1'b0;
    wait_done(40, n);
    chk("t5_latency", n, 11);
    check_digit(3, S_MINUS, "t5_d3");
    check_digit(2, S_BLANK, "t5_d2");
    check_digit(1, S_BLANK, "t5_d1");
    check_digit(0, S_4, "t5_d0");

    // 6: scan order and dwell with DIV=4
    k = 0;
    while (an !== 4'b0111 && k < 40) begin @(negedge clk); k++; end
    while (an === 4'b0111 && k < 40) begin @(negedge clk); k++; end
    chk("t6_sync", (k < 40), 1'b1);
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk("t6_an", an, an_seq[s]);
        chk("t6_onehot", $countones(~an), 1);
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcd_sumres_scan.md
Name: bcd_sumres_scan

Overview:
- Parametrised successor to the 4-bit add/subtract 7-segment top.
- Takes two WIDTH-bit unsigned operands and an add/subtract select, and forms the signed result as sign plus magnitude.
- Converts the magnitude to BCD with a sequential double-dabble state machine, then drives an NDIG-digit multiplexed 7-segment display.
- The leftmost digit carries the minus sign; leading-zero blanking applies to the remaining digits.

Parameters:
- WIDTH, 8, operand width in bits (2..16).
- NDIG, 4, number of display digits. Requires NDIG-1 >= decimal digits of 2^(WIDTH+1)-2.
- DIV, 50000, scan prescaler: the digit advances every DIV clock cycles (DIV >= 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- selector_suma_resta  in  1  0 = A+B, 1 = A-B.
- input_top_1  in  WIDTH  operand A, unsigned.
- input_top_2  in  WIDTH  operand B, unsigned.
- SSeg  out  7  segments, active-low; SSeg[0]=a ... SSeg[6]=g.
- an  out  NDIG  digit anodes, active-low, exactly one low; an[0] = units.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the display registers update.

Behaviour:
- Reset values (asynchronous):
  - State IDLE; busy=0, done=0.
  - Display BCD registers all 0, sign register 0.
  - Scan index 0, prescaler 0, so an = all ones except an[0]=0, and SSeg=7'b1000000 ("0").
  - The "first" flag is set, forcing one conversion after reset release.
- Arithmetic, on the captured snapshot:
  - Add: mag = A+B (WIDTH+1 bits), neg=0.
  - Subtract with A>=B: mag = A-B, neg=0.
  - Subtract with A<B: mag = B-A, neg=1.
  - A zero result always has neg=0, so there is no "-0".
- FSM state IDLE:
  - If first=1 or {sel,A,B} differs from the snapshot: capture the snapshot on this edge and clear first.
  - Load the shift register with mag and clear the BCD accumulator.
  - Set counter=0, busy=1, go to SHIFT.
  - Otherwise stay in IDLE.
- FSM state SHIFT: runs exactly WIDTH+1 cycles.
  - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - When the last shift completes, go to DONE.
- FSM state DONE, lasting one cycle:
  - Copy the BCD accumulator and neg into the display registers; done=1, busy=0.
  - Return to IDLE.
- Latency: edge capturing the snapshot to the edge the display updates = WIDTH+2 cycles.
- Input changes during SHIFT/DONE are ignored. The conversion completes with the old snapshot, and IDLE detects the mismatch on the next cycle, starting a new conversion. Back-to-back conversion period = WIDTH+3 cycles.
- Display never shows partial conversion data; it holds the last completed result.
- Scan:
  - The prescaler counts 0..DIV-1; on wrap the scan index increments modulo NDIG.
  - The scan runs independently of the FSM.
- Digit content, for index i:
  - i = NDIG-1: minus sign (only g lit, 7'b0111111) if neg=1, else blank (7'b1111111).
  - i < NDIG-1: the BCD digit i. It is blanked if i>0 and all digits i..NDIG-2 are zero, so the units digit always shows.
  - BCD values 0-9 use standard patterns; any other value displays blank.
- Reset asserted mid-conversion: immediate return to the reset state; the display shows "0". After release, a conversion of the current inputs starts on the first clock.
- Extremes must be exact:
  - Maximum sum 2^(WIDTH+1)-2.
  - Maximum negative -(2^WIDTH-1).

Test Plan:
1. WIDTH=8, NDIG=4. Reset, then A=255, B=255, sel=0 → done pulse WIDTH+2=10 cycles after capture; digits (3..0) = blank,5,1,0; neg=0.
2. A=3, B=10, sel=1 → digits = "-", blank, blank, 7; digit-3 SSeg=7'b0111111, digit-0 SSeg=7'b1111000.
3. A=0, B=0, sel=1 → no minus; digits = blank, blank, blank, 0; SSeg on an[0] = 7'b1000000.
4. Start 100+23, and change B to 200 three cycles after capture → first done shows 123; a second conversion starts the next cycle, with done after WIDTH+2 more cycles showing 300; busy is high across both except IDLE gaps.
5. Assert reset during SHIFT → busy=0 immediately, display "0", an=1110. Release with A=5, B=9, sel=1 → "-   4" after 10 cycles.
6. DIV=4 → an sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles; exactly one anode low at all times.
